// File: rtl/cp0_exc_seq_if.sv
// CP0 register-file write port driven by the exception sequencer.
// master drives the port, slave is the CP0 register file side.
interface cp0_exc_seq_if;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] data;
  logic        hw;

  modport master (
    output we,
    output waddr,
    output data,
    output hw
  );

  modport slave (
    input we,
    input waddr,
    input data,
    input hw
  );
endinterface

// File: rtl/cp0_exc_seq.sv
// Exception/ERET sequencer between MEM and the CP0 register file.
// Serialises EPC/Cause/Status writes, then flushes and redirects.
module cp0_exc_seq #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
  parameter logic [4:0]  ADDR_EPC    = 5'd14,
  parameter logic [4:0]  ADDR_CAUSE  = 5'd13,
  parameter logic [4:0]  ADDR_STATUS = 5'd12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         exc_valid_i,
  input  logic [4:0]   exc_type_i,
  input  logic [31:0]  pc_i,
  input  logic         in_delayslot_i,
  input  logic [31:0]  cp0_status_i,
  input  logic [31:0]  cp0_cause_i,
  input  logic [31:0]  cp0_epc_i,
  input  logic         wb_cp0_we_i,
  input  logic [4:0]   wb_cp0_waddr_i,
  input  logic [31:0]  wb_cp0_data_i,
  cp0_exc_seq_if.master cp0,
  output logic         stall_o,
  output logic         flush_o,
  output logic [31:0]  new_pc_o,
  output logic         busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    W_EPC,
    W_CAUSE,
    W_STATUS,
    REDIRECT
  } state_t;

  state_t state, state_nx;

  logic [31:0] status_eff, cause_eff, epc_eff;
  logic        int_pend;
  logic        take, eret_sel, detect;
  logic [4:0]  code_sel;

  logic [4:0]  code_q;
  logic        bd_q;
  logic        eret_q;
  logic [31:0] epcv_q;
  logic [31:0] status_q;
  logic [31:0] cause_q;
  logic [31:0] epc_q;

  // Bypass a same-cycle WB MTC0 into the CP0 values we look at
  always_comb begin
    status_eff = cp0_status_i;
    cause_eff  = cp0_cause_i;
    epc_eff    = cp0_epc_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == ADDR_STATUS)
      status_eff = wb_cp0_data_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == ADDR_CAUSE)
      cause_eff = wb_cp0_data_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == ADDR_EPC)
      epc_eff = wb_cp0_data_i;
  end

  assign int_pend = status_eff[0] & ~status_eff[1] &
                    (|(cause_eff[15:8] & status_eff[15:8]));

  // Prioritise the pending cause; interrupt first, eret last
  always_comb begin
    take     = 1'b1;
    eret_sel = 1'b0;
    code_sel = 5'd0;
    if (int_pend)           code_sel = 5'd0;
    else if (exc_type_i[1]) code_sel = 5'd8;
    else if (exc_type_i[0]) code_sel = 5'd10;
    else if (exc_type_i[2]) code_sel = 5'd13;
    else if (exc_type_i[3]) code_sel = 5'd12;
    else if (exc_type_i[4]) eret_sel = 1'b1;
    else                    take     = 1'b0;
  end

  assign detect = (state == IDLE) & exc_valid_i & take;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state sequencing
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (detect) begin
          if (eret_sel)           state_nx = W_STATUS;
          else if (status_eff[1]) state_nx = W_CAUSE;
          else                    state_nx = W_EPC;
        end
      end
      W_EPC:    state_nx = W_CAUSE;
      W_CAUSE:  state_nx = W_STATUS;
      W_STATUS: state_nx = REDIRECT;
      REDIRECT: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Snapshot everything the sequence needs at detection
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q   <= '0;
      bd_q     <= 1'b0;
      eret_q   <= 1'b0;
      epcv_q   <= '0;
      status_q <= '0;
      cause_q  <= '0;
      epc_q    <= '0;
    end else if (detect) begin
      code_q   <= code_sel;
      bd_q     <= in_delayslot_i;
      eret_q   <= eret_sel;
      epcv_q   <= in_delayslot_i ? pc_i - 32'd4 : pc_i;
      status_q <= status_eff;
      cause_q  <= cause_eff;
      epc_q    <= epc_eff;
    end
  end

  logic        bd_bit;
  logic [31:0] cause_wr;

  // Nested exceptions (EXL set) keep the old BD bit
  assign bd_bit   = status_q[1] ? cause_q[31] : bd_q;
  assign cause_wr = (cause_q & 32'h7FFF_FF83) |
                    {bd_bit, 24'd0, code_q, 2'd0};

  // Drive the CP0 port, stall and redirect per state
  always_comb begin
    cp0.we    = 1'b0;
    cp0.waddr = '0;
    cp0.data  = '0;
    cp0.hw    = 1'b0;
    stall_o   = 1'b0;
    flush_o   = 1'b0;
    new_pc_o  = '0;
    busy_o    = 1'b0;
    if (!rst) begin
      busy_o = (state != IDLE);
      unique case (state)
        IDLE: begin
          cp0.we    = wb_cp0_we_i;
          cp0.waddr = wb_cp0_waddr_i;
          cp0.data  = wb_cp0_data_i;
          stall_o   = detect;
        end
        W_EPC: begin
          cp0.we    = 1'b1;
          cp0.waddr = ADDR_EPC;
          cp0.data  = epcv_q;
          stall_o   = 1'b1;
        end
        W_CAUSE: begin
          cp0.we    = 1'b1;
          cp0.waddr = ADDR_CAUSE;
          cp0.data  = cause_wr;
          cp0.hw    = 1'b1;
          stall_o   = 1'b1;
        end
        W_STATUS: begin
          cp0.we    = 1'b1;
          cp0.waddr = ADDR_STATUS;
          cp0.data  = {status_q[31:2], ~eret_q, status_q[0]};
          stall_o   = 1'b1;
        end
        REDIRECT: begin
          flush_o  = 1'b1;
          new_pc_o = eret_q ? epc_q : EXC_VECTOR;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_exc_seq.sv
// Randomised scoreboard bench for the CP0 exception sequencer.
// A reference model queues expected CP0 writes and redirects.
module tb_cp0_exc_seq;

  localparam logic [31:0] VEC = 32'h0000_0020;

  logic        clk;
  logic        rst = 1'b1;
  logic        exc_valid;
  logic [4:0]  exc_type;
  logic [31:0] pc;
  logic        bd;
  logic [31:0] st_i, ca_i, ep_i;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        stall, flush, busy;
  logic [31:0] new_pc;

  cp0_exc_seq_if cp0();

  cp0_exc_seq dut (
    .clk           (clk),
    .rst           (rst),
    .exc_valid_i   (exc_valid),
    .exc_type_i    (exc_type),
    .pc_i          (pc),
    .in_delayslot_i(bd),
    .cp0_status_i  (st_i),
    .cp0_cause_i   (ca_i),
    .cp0_epc_i     (ep_i),
    .wb_cp0_we_i   (wb_we),
    .wb_cp0_waddr_i(wb_wa),
    .wb_cp0_data_i (wb_wd),
    .cp0           (cp0),
    .stall_o       (stall),
    .flush_o       (flush),
    .new_pc_o      (new_pc),
    .busy_o        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          is_flush;
    logic [4:0]  addr;
    logic [31:0] data;
    bit          hw;
  } ev_t;

  ev_t sbq[$];
  bit  exp_stall[int];
  bit  exp_busy[int];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic push_ev(int c, int ab, bit f, logic [4:0] a,
                         logic [31:0] d, bit h);
    ev_t e;
    if (ab >= 0 && c >= ab) return;
    e.cyc = c; e.is_flush = f; e.addr = a; e.data = d; e.hw = h;
    sbq.push_back(e);
  endtask

  task automatic mark(int c, int ab, bit s, bit b);
    if (ab >= 0 && c >= ab) return;
    exp_stall[c] = s;
    exp_busy[c]  = b;
  endtask

  // Reference: expected outputs for the inputs applied at cycle t0
  task automatic model(int t0, int ab, output int len);
    logic [31:0] st, ca, ep, epcv, cw;
    bit ip, er;
    int code, t;
    len = 0;
    st = (wb_we && wb_wa == 5'd12) ? wb_wd : st_i;
    ca = (wb_we && wb_wa == 5'd13) ? wb_wd : ca_i;
    ep = (wb_we && wb_wa == 5'd14) ? wb_wd : ep_i;
    if (wb_we) push_ev(t0, ab, 0, wb_wa, wb_wd, 0);
    if (!exc_valid) return;
    ip = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 8'd0);
    er = 0;
    if (ip)               code = 0;
    else if (exc_type[1]) code = 8;
    else if (exc_type[0]) code = 10;
    else if (exc_type[2]) code = 13;
    else if (exc_type[3]) code = 12;
    else if (exc_type[4]) begin code = 0; er = 1; end
    else return;
    mark(t0, ab, 1, 0);
    if (er) begin
      cw = st;
      cw[1] = 1'b0;
      push_ev(t0 + 1, ab, 0, 5'd12, cw, 0);
      mark(t0 + 1, ab, 1, 1);
      push_ev(t0 + 2, ab, 1, 5'd0, ep, 0);
      mark(t0 + 2, ab, 0, 1);
      len = 2;
      return;
    end
    t = t0 + 1;
    epcv = bd ? pc - 32'd4 : pc;
    if (!st[1]) begin
      push_ev(t, ab, 0, 5'd14, epcv, 0);
      mark(t, ab, 1, 1);
      t++;
    end
    cw = ca;
    cw[6:2] = code[4:0];
    if (!st[1]) cw[31] = bd;
    push_ev(t, ab, 0, 5'd13, cw, 1);
    mark(t, ab, 1, 1);
    cw = st;
    cw[1] = 1'b1;
    push_ev(t + 1, ab, 0, 5'd12, cw, 0);
    mark(t + 1, ab, 1, 1);
    push_ev(t + 2, ab, 1, 5'd0, VEC, 0);
    mark(t + 2, ab, 0, 1);
    len = t + 2 - t0;
  endtask

  task automatic clean();
    exc_valid = 0; exc_type = 0; pc = 0; bd = 0;
    st_i = 0; ca_i = 0; ep_i = 0;
    wb_we = 0; wb_wa = 0; wb_wd = 0;
  endtask

  task automatic junk();
    exc_valid = 1'($urandom);
    exc_type  = 5'($urandom);
    pc        = $urandom;
    bd        = 1'($urandom);
    st_i      = $urandom;
    ca_i      = $urandom;
    ep_i      = $urandom;
    wb_we     = 1'($urandom);
    wb_wa     = 5'($urandom);
    wb_wd     = $urandom;
  endtask

  task automatic txn(bit v, logic [4:0] ty, logic [31:0] p, bit b,
                     logic [31:0] s, logic [31:0] c, logic [31:0] e,
                     bit we, logic [4:0] wa, logic [31:0] wd);
    int len;
    @(posedge clk); #1;
    exc_valid = v; exc_type = ty; pc = p; bd = b;
    st_i = s; ca_i = c; ep_i = e;
    wb_we = we; wb_wa = wa; wb_wd = wd;
    model(cyc, -1, len);
    repeat (len) begin
      @(posedge clk); #1;
      junk();
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents an output
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        e = sbq.pop_front();
        checks++; errors++;
        $display("FAIL missed_event cyc=%0d actual=none expected_cyc=%0d",
                 cyc, e.cyc);
      end
      chk("stall", 32'(stall),
          32'(exp_stall.exists(cyc) ? exp_stall[cyc] : 1'b0));
      chk("busy", 32'(busy),
          32'(exp_busy.exists(cyc) ? exp_busy[cyc] : 1'b0));
      if (cp0.we) begin
        if (sbq.size() == 0 || sbq[0].cyc != cyc || sbq[0].is_flush) begin
          checks++; errors++;
          $display("FAIL unexpected_write cyc=%0d actual=%0d:%h expected=none",
                   cyc, cp0.waddr, cp0.data);
        end else begin
          e = sbq.pop_front();
          chk("waddr", 32'(cp0.waddr), 32'(e.addr));
          chk("wdata", cp0.data, e.data);
          chk("whw", 32'(cp0.hw), 32'(e.hw));
        end
      end
      if (flush) begin
        if (sbq.size() == 0 || sbq[0].cyc != cyc || !sbq[0].is_flush) begin
          checks++; errors++;
          $display("FAIL unexpected_flush cyc=%0d actual=%h expected=none",
                   cyc, new_pc);
        end else begin
          e = sbq.pop_front();
          chk("new_pc", new_pc, e.data);
        end
      end
    end
  end

  initial begin
    int len;
    logic [4:0] ty;
    clean();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;

    // syscall, no bd
    txn(1, 5'b00010, 32'h100, 0, 32'h1, 32'h0, 32'h0, 0, 0, 0);
    // overflow in delay slot
    txn(1, 5'b01000, 32'h204, 1, 32'h1, 32'h0, 32'h0, 0, 0, 0);
    // nested: EXL set, BD kept
    txn(1, 5'b00010, 32'h300, 1, 32'h3, 32'h8000_0000, 0, 0, 0, 0);
    txn(1, 5'b00001, 32'h304, 1, 32'h3, 32'h0000_0000, 0, 0, 0, 0);
    // eret
    txn(1, 5'b10000, 32'h500, 0, 32'h3, 32'h0, 32'h400, 0, 0, 0);
    // interrupt beats syscall
    txn(1, 5'b00010, 32'h600, 0, 32'h401, 32'h400, 0, 0, 0, 0);
    // WB MTC0 Status bypass
    txn(1, 5'b00010, 32'h700, 0, 32'h0, 32'h0, 0, 1, 5'd12, 32'h401);
    // pc wrap with bd
    txn(1, 5'b00100, 32'h0, 1, 32'h1, 32'h0, 0, 0, 0, 0);
    // valid but nothing to do, plus a plain passthrough
    txn(1, 5'b00000, 32'h800, 0, 32'h1, 32'h0, 0, 1, 5'd9, 32'hABCD);

    // reset asserted two cycles after detection
    @(posedge clk); #1;
    clean();
    exc_valid = 1; exc_type = 5'b00010; pc = 32'h900; st_i = 32'h1;
    model(cyc, cyc + 2, len);
    @(posedge clk); #1; junk();
    @(posedge clk); #1; junk(); rst = 1;
    @(posedge clk); #1; rst = 0; clean();
    repeat (3) begin @(posedge clk); #1; end

    for (int i = 0; i < 300; i++) begin
      ty = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      txn(($urandom_range(0, 3) != 0), ty, $urandom, 1'($urandom),
          $urandom, $urandom, $urandom, 1'($urandom),
          5'($urandom_range(10, 15)), $urandom);
    end

    @(posedge clk); #1;
    clean();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL leftover_events actual=%0d expected=0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
